// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one UART TX serializer
// between NUM_REQ byte-stream requesters.
//
// A grant is held from a packet's first byte until the byte flagged last. The
// accepted byte goes into a single output register (one-cycle latency, full
// throughput).
//
// Handshake (valid/ready, on every interface):
//   - A byte moves in any cycle where valid and ready are both high.
//   - A source holding valid high keeps its data stable until the transfer.
//   - Ready may depend combinationally on valid; valid never waits on ready.
//
// Optional feature macro: UART_ARB_TIMEOUT_EN. When it is defined, a lock
// whose owner has gone quiet for LOCK_TIMEOUT cycles is released and
// timeout_o pulses. When it is undefined, a lock is held until the last byte.
//
// dbg_state_o exposes the FSM state (0 = IDLE, 1 = LOCKED).
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int LOCK_TIMEOUT = 255
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [8*NUM_REQ-1:0]         req_data_i,
    input  logic [NUM_REQ-1:0]           req_last_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    output logic                         tx_valid_o,
    output logic [7:0]                   tx_data_o,
    input  logic                         tx_ready_i,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id_o,
    output logic                         busy_o,
    output logic                         timeout_o,
    output logic                         dbg_state_o
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] owner_q, owner_d;

    logic            tx_valid_q;
    logic [7:0]      tx_data_q;
    logic [ID_W-1:0] grant_q;

    logic            slot_free;
    logic            win_found;
    logic [ID_W-1:0] win_id;
    logic            accept;
    logic [ID_W-1:0] acc_id;
    logic            acc_last;
    logic [7:0]      acc_data;
    logic            timeout_hit;

    // The output register can take a new byte when it is empty or draining now.
    assign slot_free = !tx_valid_q || tx_ready_i;

    // Round-robin pick: first valid requester scanning upward from ptr+1.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (!win_found && req_valid_i[idx]) begin
                win_found = 1'b1;
                win_id    = idx[ID_W-1:0];
            end
        end
    end

    // Output decode: ready goes only to the owner (LOCKED) or winner (IDLE).
    always_comb begin
        req_ready_o = '0;
        if (!reset_i) begin
            if (state_q == ST_LOCKED) begin
                req_ready_o[owner_q] = slot_free;
            end else if (win_found) begin
                req_ready_o[win_id] = slot_free;
            end
        end
    end

    assign accept = |(req_valid_i & req_ready_o);
    assign acc_id = (state_q == ST_LOCKED) ? owner_q : win_id;

    // Mux the accepted requester's byte and last flag.
    always_comb begin
        acc_data = 8'h00;
        acc_last = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (acc_id == ID_W'(k)) begin
                acc_data = req_data_i[8*k +: 8];
                acc_last = req_last_i[k];
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] lock_cnt_q;

    // Fires while the quiet-owner count sits at the limit; an owner transfer
    // in the same cycle wins and suppresses the release.
    assign timeout_hit = (state_q == ST_LOCKED) &&
                         (lock_cnt_q == 16'(LOCK_TIMEOUT)) && !accept;

    // Count LOCKED cycles in which the owner offers nothing.
    always_ff @(posedge clk_i) begin
        if (reset_i || state_q == ST_IDLE || accept || timeout_hit) begin
            lock_cnt_q <= 16'h0000;
        end else if (!req_valid_i[owner_q]) begin
            lock_cnt_q <= lock_cnt_q + 16'h0001;
        end
    end
`else
    logic unused_lock_timeout;
    assign unused_lock_timeout = |16'(LOCK_TIMEOUT);
    assign timeout_hit         = 1'b0;
`endif

    // FSM state register plus round-robin pointer and lock owner.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= ID_W'(NUM_REQ - 1);
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    // FSM next state: lock on a non-last byte, release on last or timeout.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (acc_last) begin
                        ptr_d = win_id;
                    end else begin
                        state_d = ST_LOCKED;
                        owner_d = win_id;
                    end
                end
            end
            ST_LOCKED: begin
                if ((accept && acc_last) || timeout_hit) begin
                    state_d = ST_IDLE;
                    ptr_d   = owner_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output stage: load on accept, otherwise empty once the serializer takes it.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            grant_q    <= '0;
        end else if (accept) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= acc_data;
            grant_q    <= acc_id;
        end else if (tx_ready_i) begin
            tx_valid_q <= 1'b0;
        end
    end

    // FSM-derived status outputs.
    always_comb begin
        tx_valid_o  = tx_valid_q;
        tx_data_o   = tx_data_q;
        grant_id_o  = grant_q;
        busy_o      = (state_q == ST_LOCKED) || tx_valid_q;
        timeout_o   = timeout_hit;
        dbg_state_o = state_q;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter sharing the single UART transmitter between `NUM_REQ` byte-stream requesters, e.g. the core's MMIO console port and the debug/trace port. Sits between the requesters and the UART TX serializer feeding `uart_tx_o`. Packets from different requesters never interleave: a grant is held from the first byte until the byte flagged `last`. A registered output stage gives one-cycle latency and full throughput.

## Interface
- `NUM_REQ`, 2: number of requesters; legal range 2..8.
- `LOCK_TIMEOUT`, 255: idle cycles before a held grant is forcibly released; used only with the timeout feature; legal range 1..65535.
- `clk_i` in 1: system clock; all logic on rising edge.
- `reset_i` in 1: synchronous, active-high reset.
- `req_valid_i` in NUM_REQ: per-requester byte valid.
- `req_data_i` in 8*NUM_REQ: per-requester byte; requester k uses bits [8k+7:8k].
- `req_last_i` in NUM_REQ: byte is the last of its packet.
- `req_ready_o` out NUM_REQ: per-requester accept; at most one bit high.
- `tx_valid_o` out 1: byte available to the serializer.
- `tx_data_o` out 8: byte to transmit.
- `tx_ready_i` in 1: serializer accepts the byte this cycle.
- `grant_id_o` out $clog2(NUM_REQ): current or most recent owner.
- `busy_o` out 1: high in LOCKED or while `tx_valid_o` is high.
- `timeout_o` out 1: one-cycle pulse on forced lock release.

## Operation
- Transfer on requester k: `req_valid_i[k] && req_ready_o[k]`. Transfer on output: `tx_valid_o && tx_ready_i`.
- Slot free: `slot_free = !tx_valid_o || tx_ready_i`.
- FSM states:
  - IDLE: the winner is the first valid requester scanning from `ptr+1` modulo NUM_REQ. `req_ready_o[winner] = slot_free`. On transfer with `last=1`: stay in IDLE and set `ptr <= winner`. On transfer with `last=0`: go to LOCKED and set `owner <= winner`.
  - LOCKED: only `req_ready_o[owner] = slot_free`; all other requesters see ready low. On owner transfer with `last=1`: go to IDLE and set `ptr <= owner`.
- Each accepted byte loads `tx_data_o` and sets `tx_valid_o` on the next edge. `tx_valid_o` clears after an output transfer unless a new byte is loaded in the same cycle.
- `tx_data_o` is stable while `tx_valid_o && !tx_ready_i`.
- `grant_id_o` updates on each accepted byte.
- Requester contract: once `req_valid_i[k]` is high it holds its data until the transfer. The arbiter does not check this.

## Timing
- Reset values:
  - state IDLE
  - `ptr = NUM_REQ-1`, so requester 0 has first priority
  - `tx_valid_o=0`, `tx_data_o=8'h00`
  - `grant_id_o=0`, `busy_o=0`, `timeout_o=0`
  - timeout counter 0
  - `req_ready_o` all 0 while `reset_i` is high
- Latency: the byte accepted in cycle N appears on `tx_valid_o`/`tx_data_o` in cycle N+1.
- Throughput: 1 byte/cycle while `tx_ready_i` stays high.
- Simultaneous output transfer and new acceptance: the register reloads and `tx_valid_o` stays high with no bubble.
- Backpressure: `tx_ready_i=0` with `tx_valid_o=1` drops all `req_ready_o` in that cycle.
- Reset mid-packet: the pending output byte is discarded, the lock is dropped and `ptr` is restored. The serializer must tolerate `tx_valid_o` dropping.
- Owner deasserting `req_valid_i` while LOCKED: the lock is held, and other requesters stall, until the owner's `last` byte is transferred.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to LOCKED and on every owner transfer.
  - It increments each LOCKED cycle in which `req_valid_i[owner]=0`.
  - When it reaches `LOCK_TIMEOUT`, on the next edge: state goes to IDLE, `ptr <= owner`, counter clears, and `timeout_o` pulses high for one cycle.
  - An owner transfer in the same cycle takes precedence over the timeout.
- `UART_ARB_TIMEOUT_EN` undefined: there is no counter, the lock is held indefinitely, and `timeout_o` is tied to 0.

## Test plan
- Reset then idle: `reset_i=1` for 2 cycles, no requests -> all outputs at reset values; `busy_o=0`; `req_ready_o=0`.
- Single-byte packets, equal contention: NUM_REQ=2, both requesters continuously valid with `last=1`, data 0xA0/0xB0, `tx_ready_i=1` -> `tx_data_o` alternates 0xA0, 0xB0, 0xA0… starting with requester 0, one byte per cycle, each byte one cycle after acceptance.
- Packet lock: requester 1 sends 0x11, 0x12, 0x13 (last on 0x13) while requester 0 is valid throughout -> output 0x11, 0x12, 0x13 contiguous, then requester 0's byte; `req_ready_o[0]=0` during the packet.
- Backpressure: `tx_ready_i=0` for 5 cycles with `tx_valid_o=1`, data 0x5A -> `tx_data_o` holds 0x5A, `req_ready_o=0`; the next byte follows on the cycle after `tx_ready_i` rises.
- Timeout (`UART_ARB_TIMEOUT_EN`, LOCK_TIMEOUT=4): requester 0 sends one byte with `last=0` then goes idle; requester 1 is valid -> `timeout_o` pulses 5 cycles after the transfer; requester 1's byte is accepted the cycle after.
- Reset mid-packet: assert `reset_i` during a locked 3-byte packet after byte 2 -> next cycle `tx_valid_o=0`, state IDLE, and requester 0 wins the first post-reset contention.
